// File: rtl/index_selector_pkg.sv
// ============================================================================
// Module   : index_selector_pkg
// Purpose  : Shared switch-count and index-width constants for the switch
//            index selector and the ALU select logic that consumes it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package index_selector_pkg;

    localparam int C_SWITCH_WIDTH = 8;

    // Width of a binary index that can address any of WIDTH switches
    function automatic int index_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int C_INDEX_WIDTH = index_width(C_SWITCH_WIDTH);

endpackage : index_selector_pkg

`default_nettype wire

// File: rtl/index_selector_priority_encoder.sv
// ============================================================================
// Module   : index_priority_encoder
// Purpose  : Combinational highest-set-bit encoder with any-set and
//            multi-set flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module index_priority_encoder
    import index_selector_pkg::*;
#(
    parameter int WIDTH   = C_SWITCH_WIDTH,
    parameter int INDEX_W = index_width(WIDTH)
) (
    input  logic [WIDTH-1:0]   i_vec,
    output logic [INDEX_W-1:0] o_index,
    output logic               o_any,
    output logic               o_multi
);

    logic [INDEX_W-1:0] w_index;

    // Ascending scan: the last set bit seen is the highest, so it wins
    always_comb begin
        w_index = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_vec[i]) begin
                w_index = i[INDEX_W-1:0];
            end
        end
    end

    assign o_index = w_index;
    assign o_any   = |i_vec;
    // Clearing the lowest set bit leaves something only if two or more were set
    assign o_multi = |(i_vec & (i_vec - WIDTH'(1)));

endmodule : index_priority_encoder

`default_nettype wire

// File: rtl/index_selector.sv
// ============================================================================
// Module   : index_selector
// Purpose  : Registers the binary index of the highest active slide switch,
//            plus valid / multi-hot status; index holds when no switch is on.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module index_selector
    import index_selector_pkg::*;
#(
    parameter int WIDTH   = C_SWITCH_WIDTH,
    parameter int INDEX_W = index_width(WIDTH)
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [WIDTH-1:0]   Switches,
    output logic [INDEX_W-1:0] Index,
    output logic               Valid,
    output logic               MultiHot
);

    logic [INDEX_W-1:0] w_enc_index;
    logic               w_any;
    logic               w_multi;

    logic [INDEX_W-1:0] r_index;
    logic               r_valid;
    logic               r_multi;

    index_priority_encoder #(
        .WIDTH   (WIDTH),
        .INDEX_W (INDEX_W)
    ) u_encoder (
        .i_vec   (Switches),
        .o_index (w_enc_index),
        .o_any   (w_any),
        .o_multi (w_multi)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_index <= '0;
            r_valid <= 1'b0;
            r_multi <= 1'b0;
        end else begin
            r_valid <= w_any;
            r_multi <= w_multi;
            // All switches off keeps the last selection for the ALU
            if (w_any) begin
                r_index <= w_enc_index;
            end
        end
    end

    assign Index    = r_index;
    assign Valid    = r_valid;
    assign MultiHot = r_multi;

endmodule : index_selector

`default_nettype wire

// File: tb/tb_index_selector.sv
// ============================================================================
// Module   : tb_index_selector
// Purpose  : Directed self-checking bench for index_selector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_index_selector;

    logic       Clock;
    logic       Reset;
    logic [7:0] Switches;
    logic [2:0] Index;
    logic       Valid;
    logic       MultiHot;

    int n_cmp;
    int n_err;

    index_selector dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Switches (Switches),
        .Index    (Index),
        .Valid    (Valid),
        .MultiHot (MultiHot)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] ei, input logic ev, input logic em);
        chk({tag, ".index"}, {5'd0, Index}, {5'd0, ei});
        chk({tag, ".valid"}, {7'd0, Valid}, {7'd0, ev});
        chk({tag, ".multi"}, {7'd0, MultiHot}, {7'd0, em});
    endtask

    // Drive on the falling edge, sample 1 time unit after the next rising edge
    task automatic step(input logic [7:0] sw);
        @(negedge Clock);
        Switches = sw;
        @(posedge Clock);
        #1;
    endtask

    initial begin
        logic [2:0] m_index;
        logic [2:0] m_hi;
        int         m_cnt;
        logic [7:0] v;

        n_cmp    = 0;
        n_err    = 0;
        Reset    = 1'b1;
        Switches = 8'h00;

        // Reset for two edges
        @(posedge Clock);
        @(posedge Clock);
        #1;
        chk_all("reset", 3'd0, 1'b0, 1'b0);
        @(negedge Clock);
        Reset = 1'b0;

        // Idle after reset: index stays 0
        step(8'h00);
        chk_all("idle_after_reset", 3'd0, 1'b0, 1'b0);

        // One-hot walk
        for (int k = 0; k < 8; k++) begin
            v = 8'h01 << k;
            step(v);
            chk_all($sformatf("walk%0d", k), k[2:0], 1'b1, 1'b0);
        end

        // Priority
        step(8'b0010_0101);
        chk_all("prio_25", 3'd5, 1'b1, 1'b1);
        step(8'b1111_1111);
        chk_all("prio_ff", 3'd7, 1'b1, 1'b1);
        step(8'b1000_0001);
        chk_all("prio_81", 3'd7, 1'b1, 1'b1);

        // Hold on zero
        step(8'b0000_1000);
        chk_all("hold_pre", 3'd3, 1'b1, 1'b0);
        step(8'b0000_0000);
        chk_all("hold_zero", 3'd3, 1'b0, 1'b0);
        step(8'b0000_0010);
        chk_all("hold_post", 3'd1, 1'b1, 1'b0);

        // Reset mid-operation
        step(8'b0100_0000);
        chk_all("mid_pre", 3'd6, 1'b1, 1'b0);
        @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        chk_all("mid_reset", 3'd0, 1'b0, 1'b0);
        @(negedge Clock);
        Reset = 1'b0;
        @(posedge Clock);
        #1;
        chk_all("mid_release", 3'd6, 1'b1, 1'b0);

        // Latency: change between edges, outputs must not move until next edge
        Switches = 8'b0000_0110;
        #2;
        chk_all("latency_between", 3'd6, 1'b1, 1'b0);
        @(negedge Clock);
        chk_all("latency_negedge", 3'd6, 1'b1, 1'b0);
        @(posedge Clock);
        #1;
        chk_all("latency_after", 3'd2, 1'b1, 1'b1);

        // Exhaustive against a popcount / highest-bit model with hold-on-zero
        m_index = 3'd2;
        for (int n = 0; n < 256; n++) begin
            v     = n[7:0];
            m_hi  = 3'd0;
            m_cnt = 0;
            for (int b = 7; b >= 0; b--) begin
                if (v[b]) begin
                    if (m_cnt == 0) m_hi = b[2:0];
                    m_cnt++;
                end
            end
            if (m_cnt > 0) m_index = m_hi;
            step(v);
            chk_all($sformatf("exh%0d", n), m_index, m_cnt > 0, m_cnt >= 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_index_selector

`default_nettype wire

// File: doc/index_selector.md
Name: index_selector

Overview:
- Converts the 8 board slide-switch inputs into a 3-bit binary index that selects the ALU operation or operand slot.
- A single asserted switch at bit position k yields Index = k.
- The output is registered on the codebase clock and carries status flags for "no switch" and "more than one switch".
- Sits between the switch input pins and the ALU operation-select logic.

Parameters:
- WIDTH, 8, number of switch inputs; must be a power of two, at least 2.
- INDEX_W, $clog2(WIDTH) = 3, width of Index. Derived; do not override.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset; sampled on the rising edge of Clock.
- Switches  input  WIDTH (8)  switch levels; bit k high means switch k is on.
- Index  output  INDEX_W (3)  registered binary position of the selected switch.
- Valid  output  1  registered; 1 when at least one switch was high at the last sample.
- MultiHot  output  1  registered; 1 when two or more switches were high at the last sample.

Behaviour:
- Timing:
  - Switches is sampled on each rising edge of Clock.
  - Index, Valid and MultiHot update on that same edge.
  - Latency is exactly 1 cycle from a Switches change to the outputs.
  - No combinational path from Switches to any output.
- Reset:
  - Reset is synchronous and active-high, and has priority over everything else.
  - While Reset is high at a rising edge: Index = 0, Valid = 0, MultiHot = 0.
  - After the first non-reset edge, the outputs reflect the Switches value sampled on that edge.
- One-hot input (bit k only): Index = k, Valid = 1, MultiHot = 0.
  - 8'b00000001 gives 0, 8'b00000010 gives 1, up to 8'b10000000 giving 7.
- Multiple bits set:
  - Highest-numbered set bit wins; Index = its position.
  - Valid = 1, MultiHot = 1.
- All zero:
  - Index holds its previous registered value. It is not forced to 0.
  - Valid = 0, MultiHot = 0.
  - After reset with all switches off, Index stays 0.
- Index is always in the range 0..WIDTH-1. No out-of-range encoding exists.
- MultiHot is computed from the same sample as Index; the two are never one cycle apart.
- Reset asserted mid-operation: the outputs clear on the next edge regardless of Switches. The held Index value is lost.
- Switches are assumed stable relative to Clock. Board-level synchronisation and debounce are done upstream and are not part of this block.

Decomposition:
- Shared package: the WIDTH default (8) and the derived INDEX_W, so ALU select logic and this block agree on width.
- One combinational sub-module, index_priority_encoder:
  - Input: WIDTH-bit vector.
  - Outputs: INDEX_W-bit index of the highest set bit, an any-set flag and a multi-set flag.
  - No clock.
- index_selector wraps the sub-module with the output registers, the hold-on-zero mux and the reset.

Test Plan:
- Reset then walk: hold Reset = 1 for 2 cycles, then release. Apply 8'b00000001, 8'b00000010, 8'b00000100, up to 8'b10000000, one per cycle. Required: Index = 0, 1, 2, up to 7, each appearing one cycle after its input, with Valid = 1 and MultiHot = 0 throughout.
- Priority: apply 8'b00100101. Next cycle: Index = 5, Valid = 1, MultiHot = 1. Then apply 8'b11111111. Next cycle: Index = 7, MultiHot = 1.
- Hold on zero: apply 8'b00001000 (Index = 3), then 8'b00000000. Required: Index stays 3, Valid = 0, MultiHot = 0. Then apply 8'b00000010: Index = 1, Valid = 1.
- Reset mid-operation: with Index = 6 and Valid = 1, assert Reset for one edge while Switches = 8'b01000000. Required: Index = 0, Valid = 0, MultiHot = 0 on that edge. Index = 6 and Valid = 1 again one edge after Reset drops.
- Latency check: change Switches between clock edges. Required: the outputs do not change until the next rising edge of Clock, so there is no combinational leak.
- Exhaustive: apply all 256 Switches values. Compare each against a model: highest set bit, popcount ≥ 2 for MultiHot, and hold-on-zero for Index.
